// File: rtl/heat_point_loader_if.sv
// Mailbox SRAM and VGA pixel SRAM bus bundle for the heat-map point loader.
// The loader drives the bus as master; the memories (or a bench) sit on the slave side.
interface heat_point_loader_if #(
  parameter int SRAM_AW = 8,
  parameter int VGA_AW  = 32
);
  logic [31:0]        sram_readdata;
  logic [SRAM_AW-1:0] sram_address;
  logic               sram_write;
  logic [31:0]        sram_writedata;
  logic [VGA_AW-1:0]  vga_sram_address;
  logic               vga_sram_write;
  logic [7:0]         vga_sram_writedata;

  modport master (
    input  sram_readdata,
    output sram_address, sram_write, sram_writedata,
    output vga_sram_address, vga_sram_write, vga_sram_writedata
  );

  modport slave (
    output sram_readdata,
    input  sram_address, sram_write, sram_writedata,
    input  vga_sram_address, vga_sram_write, vga_sram_writedata
  );
endinterface

// File: rtl/heat_point_loader.sv
// Heat-map point loader: polls the shared mailbox SRAM for a batch of packed
// (x, y, value) points, colour-maps each in-range point into the VGA pixel SRAM,
// then posts {dropped, written} status, clears the flag and re-arms.
// All bus outputs are decoded from the state register, so an asynchronous reset
// forces them to 0 immediately.
module heat_point_loader #(
  parameter int                 SRAM_AW    = 8,
  parameter int                 MAX_POINTS = 254,
  parameter int                 H_RES      = 640,
  parameter int                 V_RES      = 480,
  parameter int                 VGA_AW     = 32,
  parameter logic [VGA_AW-1:0]  VGA_BASE   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            mode,
  heat_point_loader_if.master   bus,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           frame_count
);

  typedef enum logic [3:0] {
    IDLE, POLL_W, POLL_C, CHECK,
    CNT_A, CNT_W, CNT_C,
    PT_A, PT_W, PT_C, PT_WR,
    STAT, RELEASE
  } state_t;

  state_t             state, state_nxt;
  logic [8:0]         n_eff;
  logic [8:0]         idx;
  logic [15:0]        written;
  logic [15:0]        dropped;

  logic               flag_nz;
  logic [9:0]         pt_x;
  logic [9:0]         pt_y;
  logic [7:0]         pt_colour;

  logic [8:0]         n_clamp;
  logic               in_range;

  // Signed value -> pixel colour; u = v + 128 is just the MSB flipped.
  function automatic logic [7:0] colour_map(input logic [1:0] m, input logic signed [7:0] v);
    logic [7:0] u;
    u = {~v[7], v[6:0]};
    case (m)
      2'd1:    return {u[7:5], (u[7] ? ~u[6:4] : u[6:4]), ~u[7:6]};
      2'd2:    return u;
      default: return 8'hFF;
    endcase
  endfunction

  // Requested count clamped to the batch ceiling so the point loop always terminates.
  function automatic logic [8:0] clamp_count(input logic [8:0] n);
    return (n > 9'(MAX_POINTS)) ? 9'(MAX_POINTS) : n;
  endfunction

  assign n_clamp  = clamp_count(bus.sram_readdata[8:0]);
  assign in_range = (int'(pt_x) < H_RES) && (int'(pt_y) < V_RES);

  // FSM state and batch bookkeeping (control, asynchronously reset).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      n_eff       <= '0;
      idx         <= '0;
      written     <= '0;
      dropped     <= '0;
      frame_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        CNT_C: begin
          n_eff   <= n_clamp;
          idx     <= '0;
          written <= '0;
          dropped <= '0;
        end
        PT_C:    idx <= idx + 9'd1;
        PT_WR: begin
          if (in_range) written <= written + 16'd1;
          else          dropped <= dropped + 16'd1;
        end
        RELEASE: frame_count <= frame_count + 16'd1;
        default: ;
      endcase
    end
  end

  // Mailbox data captures: flag word and the current point's fields and colour.
  always_ff @(posedge clock) begin
    if (state == POLL_C)
      flag_nz <= (bus.sram_readdata != 32'd0);
    if (state == PT_C) begin
      pt_x      <= bus.sram_readdata[29:20];
      pt_y      <= bus.sram_readdata[17:8];
      pt_colour <= colour_map(mode, bus.sram_readdata[7:0]);
    end
  end

  // Next-state and bus outputs decoded from the current state.
  always_comb begin
    state_nxt              = state;
    bus.sram_address       = '0;
    bus.sram_write         = 1'b0;
    bus.sram_writedata     = 32'd0;
    bus.vga_sram_address   = '0;
    bus.vga_sram_write     = 1'b0;
    bus.vga_sram_writedata = 8'd0;
    busy                   = (state != IDLE);
    done                   = 1'b0;

    case (state)
      IDLE:   if (enable) state_nxt = POLL_W;
      POLL_W: state_nxt = POLL_C;
      POLL_C: state_nxt = CHECK;
      CHECK:  state_nxt = flag_nz ? CNT_A : IDLE;
      CNT_A: begin
        bus.sram_address = SRAM_AW'(1);
        state_nxt        = CNT_W;
      end
      CNT_W: begin
        bus.sram_address = SRAM_AW'(1);
        state_nxt        = CNT_C;
      end
      CNT_C: begin
        bus.sram_address = SRAM_AW'(1);
        state_nxt        = (n_clamp == 9'd0) ? STAT : PT_A;
      end
      PT_A: begin
        bus.sram_address = SRAM_AW'(idx + 9'd2);
        state_nxt        = PT_W;
      end
      PT_W: begin
        bus.sram_address = SRAM_AW'(idx + 9'd2);
        state_nxt        = PT_C;
      end
      PT_C: begin
        bus.sram_address = SRAM_AW'(idx + 9'd2);
        state_nxt        = PT_WR;
      end
      PT_WR: begin
        if (in_range) begin
          bus.vga_sram_write     = 1'b1;
          bus.vga_sram_address   = VGA_BASE + VGA_AW'(pt_x) + VGA_AW'(pt_y) * VGA_AW'(H_RES);
          bus.vga_sram_writedata = pt_colour;
        end
        state_nxt = (idx == n_eff) ? STAT : PT_A;
      end
      STAT: begin
        bus.sram_address   = SRAM_AW'(1);
        bus.sram_write     = 1'b1;
        bus.sram_writedata = {dropped, written};
        state_nxt          = RELEASE;
      end
      RELEASE: begin
        bus.sram_address   = '0;
        bus.sram_write     = 1'b1;
        bus.sram_writedata = 32'd0;
        done               = 1'b1;
        state_nxt          = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
